dpram_be_init: RTL and testbench
================================

Name: dpram_be_init

Overview:
Parametrised successor to the team's two-port RAM wrapper. It keeps two independent read/write ports on one clock and adds:
- per-byte write enables;
- selectable read latency (1 or 2 cycles) with per-port read-valid strobes;
- defined same-address collision semantics;
- a post-reset clear engine that zeroes the whole array before accepting traffic.

Used as weight/activation buffer storage in the accelerator datapaths.

Parameters:
AWIDTH, 10, address width
NUM_WORDS, 1024, depth; must be <= 2**AWIDTH
DWIDTH, 32, data width; must be a multiple of 8
NBYTES, DWIDTH/8, byte-enable width (derived, not overridden)
RD_LAT, 1, read latency in cycles, legal values 1 or 2
READ_MODE, 0, cross-port read/write collision: 0 = old data, 1 = new data (forwarded)
CLEAR_ON_RESET, 1, 1 = zero the array after reset; 0 = skip the clear

Ports:
clk  in  1  clock, all logic on posedge
resetn  in  1  asynchronous active-low reset
init_done  out  1  high once the array is usable
en_a  in  1  port A request
wren_a  in  1  port A write (else read), qualified by en_a
be_a  in  NBYTES  port A byte enables
address_a  in  AWIDTH  port A address
data_a  in  DWIDTH  port A write data
out_a  out  DWIDTH  port A read data
valid_a  out  1  port A read-data strobe
en_b, wren_b, be_b, address_b, data_b, out_b, valid_b  same as port A, for port B
collision  out  1  one-cycle pulse: same-address write-write was detected
oor_err  out  1  one-cycle pulse: an accepted request had address >= NUM_WORDS

Behaviour:
Reset (asynchronous, resetn=0):
- out_a, out_b = 0; valid_a, valid_b, collision, oor_err, init_done = 0.
- Read pipelines are flushed; clear counter = 0.
- FSM goes to CLEAR if CLEAR_ON_RESET=1, else to RUN.
- Reset asserted mid-operation aborts all in-flight reads; no valid is emitted for them.

FSM:
- CLEAR: writes 0 to word cnt each cycle and increments cnt. After cnt = NUM_WORDS-1 is written, go to RUN.
- RUN: terminal state; left only by reset.
- In CLEAR, all port requests are ignored and produce no valid. They are not queued.
- init_done is 0 in CLEAR and 1 in RUN. After resetn rises it goes high NUM_WORDS+1 cycles later (CLEAR_ON_RESET=1) or 1 cycle later (CLEAR_ON_RESET=0).

Accepted request (RUN, en_x = 1):
- Read (wren_x = 0): array data appears on out_x exactly RD_LAT cycles after the request edge, with valid_x = 1 for that one cycle. out_x holds its last value otherwise. Back-to-back reads every cycle are sustained.
- Write (wren_x = 1): only bytes with be_x[i] = 1 are updated. be_x = 0 is a no-op. No valid strobe.
- Address >= NUM_WORDS:
  - write is dropped;
  - read returns 0, still with valid_x at normal latency;
  - oor_err pulses on the cycle after acceptance.

Same-address collisions (same cycle):
- Write/write: port A bytes win for every byte A enables. B bytes are written only where be_a = 0 and be_b = 1. collision pulses on the next cycle.
- Read on one port, write on the other:
  - READ_MODE = 0: read returns the pre-write word.
  - READ_MODE = 1: read returns the pre-write word with the written bytes replaced by the new data.
- Read/read: both ports return the same word.
- A collision involving an out-of-range address is not flagged; oor_err applies instead.

Timing:
- RD_LAT = 2 adds one output register stage. valid_x follows the same pipeline as the data.
- No combinational path from inputs to outputs.

Decomposition:
Shared package dpram_pkg:
- FSM state encoding: CLEAR = 1'b0, RUN = 1'b1.
- Localparams for legal RD_LAT and READ_MODE values.

One sub-module, dpram_be_core:
- Raw two-port array with byte-enable writes, 1-cycle read, old-data-on-collision.
- Behavioural array under SIMULATION_MEMORY; otherwise a dual_port_ram primitive per byte lane.

The top level owns:
- the clear FSM and counter;
- the port mux that steals port A during CLEAR;
- the collision/forwarding logic and valid pipelines.

Test Plan:
1. Reset then idle, NUM_WORDS=16, CLEAR_ON_RESET=1 -> init_done rises 17 cycles after resetn; a read of every address returns 0; a read issued during CLEAR produces no valid_a.
2. Byte enables: write 0xAABBCCDD to addr 5 with be_a=4'hF, then 0x11223344 with be_a=4'b0101 -> read on B returns 0xAA22CC44; valid_b arrives 1 cycle after the request (RD_LAT=1) or 2 cycles after (RD_LAT=2).
3. Write/write collision at addr 3: A writes 0x11111111 with be=4'b0011, B writes 0x22222222 with be=4'hF -> word reads 0x22221111; collision pulses exactly once.
4. Cross-port read/write: addr 7 holds 0x0; A reads while B writes 0xFFFF0000 with be=4'b1100 -> out_a = 0x00000000 when READ_MODE=0, 0xFFFF0000 when READ_MODE=1.
5. Out of range, NUM_WORDS=12, AWIDTH=4: write 0xDEAD to addr 13, then read addr 13 -> out = 0, valid = 1, oor_err pulses for both requests; addresses 0–11 are unchanged.
6. Reset mid-stream: continuous reads on both ports, resetn pulsed low during RD_LAT=2 -> valid_a/valid_b drop immediately; no stale valid after release; the array is re-cleared (all reads return 0).

Source files
------------

// File: rtl/dpram_pkg.sv
// Shared definitions for the byte-enable dual-port RAM: clear-FSM encoding and
// legal values of the latency / collision-mode parameters.
package dpram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int RD_LAT_MIN     = 1;
    localparam int RD_LAT_MAX     = 2;
    localparam int READ_MODE_OLD  = 0;
    localparam int READ_MODE_NEW  = 1;

endpackage

// File: rtl/dpram_be_init_if.sv
// Two-port request/response bundle for dpram_be_init, plus its status strobes.
interface dpram_be_init_if #(
    parameter int AWIDTH = 10,
    parameter int DWIDTH = 32
);
    localparam int NBYTES = DWIDTH / 8;

    logic              init_done;
    logic              en_a;
    logic              wren_a;
    logic [NBYTES-1:0] be_a;
    logic [AWIDTH-1:0] address_a;
    logic [DWIDTH-1:0] data_a;
    logic [DWIDTH-1:0] out_a;
    logic              valid_a;
    logic              en_b;
    logic              wren_b;
    logic [NBYTES-1:0] be_b;
    logic [AWIDTH-1:0] address_b;
    logic [DWIDTH-1:0] data_b;
    logic [DWIDTH-1:0] out_b;
    logic              valid_b;
    logic              collision;
    logic              oor_err;

    modport slave (
        input  en_a, wren_a, be_a, address_a, data_a,
        input  en_b, wren_b, be_b, address_b, data_b,
        output init_done, out_a, valid_a, out_b, valid_b, collision, oor_err
    );

    modport master (
        output en_a, wren_a, be_a, address_a, data_a,
        output en_b, wren_b, be_b, address_b, data_b,
        input  init_done, out_a, valid_a, out_b, valid_b, collision, oor_err
    );

endinterface

// File: rtl/dpram_be_core.sv
// Raw two-port array with per-byte writes and a 1-cycle registered read.
// Callers keep addresses in range and resolve write/write byte overlap.
module dpram_be_core #(
    parameter int AWIDTH    = 10,
    parameter int NUM_WORDS = 1024,
    parameter int DWIDTH    = 32
) (
    input  logic                    clk,
    input  logic [DWIDTH/8-1:0]     we_a,
    input  logic                    rd_a,
    input  logic [AWIDTH-1:0]       addr_a,
    input  logic [DWIDTH-1:0]       wdata_a,
    output logic [DWIDTH-1:0]       q_a,
    input  logic [DWIDTH/8-1:0]     we_b,
    input  logic                    rd_b,
    input  logic [AWIDTH-1:0]       addr_b,
    input  logic [DWIDTH-1:0]       wdata_b,
    output logic [DWIDTH-1:0]       q_b
);
    localparam int NBYTES = DWIDTH / 8;

`ifdef SIMULATION_MEMORY
    logic [DWIDTH-1:0] mem [NUM_WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NBYTES; i++) begin
            if (we_b[i]) mem[addr_b][8*i +: 8] <= wdata_b[8*i +: 8];
            if (we_a[i]) mem[addr_a][8*i +: 8] <= wdata_a[8*i +: 8];
        end
        if (rd_a) q_a <= mem[addr_a];
        if (rd_b) q_b <= mem[addr_b];
    end
`else
    for (genvar i = 0; i < NBYTES; i++) begin : g_lane
        dual_port_ram #(
            .AWIDTH (AWIDTH),
            .DEPTH  (NUM_WORDS),
            .DWIDTH (8)
        ) u_lane (
            .clk    (clk),
            .we_a   (we_a[i]),
            .rd_a   (rd_a),
            .addr_a (addr_a),
            .d_a    (wdata_a[8*i +: 8]),
            .q_a    (q_a[8*i +: 8]),
            .we_b   (we_b[i]),
            .rd_b   (rd_b),
            .addr_b (addr_b),
            .d_b    (wdata_b[8*i +: 8]),
            .q_b    (q_b[8*i +: 8])
        );
    end
`endif

endmodule

// File: rtl/dual_port_ram.sv
// Generic true dual-port RAM lane: registered read, old data on same-edge write.
module dual_port_ram #(
    parameter int AWIDTH = 10,
    parameter int DEPTH  = 1024,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              we_a,
    input  logic              rd_a,
    input  logic [AWIDTH-1:0] addr_a,
    input  logic [DWIDTH-1:0] d_a,
    output logic [DWIDTH-1:0] q_a,
    input  logic              we_b,
    input  logic              rd_b,
    input  logic [AWIDTH-1:0] addr_b,
    input  logic [DWIDTH-1:0] d_b,
    output logic [DWIDTH-1:0] q_b
);
    logic [DWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_b) mem[addr_b] <= d_b;
        if (we_a) mem[addr_a] <= d_a;
        if (rd_a) q_a <= mem[addr_a];
        if (rd_b) q_b <= mem[addr_b];
    end

endmodule

// File: rtl/dpram_be_init.sv
// Two-port byte-enable RAM with post-reset clear engine, selectable read latency,
// read-valid strobes and defined same-address collision behaviour.
module dpram_be_init
    import dpram_pkg::*;
#(
    parameter int AWIDTH         = 10,
    parameter int NUM_WORDS      = 1024,
    parameter int DWIDTH         = 32,
    parameter int RD_LAT         = 1,
    parameter int READ_MODE      = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic            clk,
    input  logic            resetn,
    dpram_be_init_if.slave  bus
);
    localparam int NBYTES = DWIDTH / 8;
    localparam int NP     = 2;
    localparam logic [AWIDTH:0]   DEPTH_W = (AWIDTH+1)'(NUM_WORDS);
    localparam logic [AWIDTH-1:0] LAST_W  = AWIDTH'(NUM_WORDS - 1);

    state_t            state, state_nx;
    logic [AWIDTH-1:0] cnt, cnt_nx;
    logic              run;
    logic              init_done_q, collision_q, oor_err_q;

    logic [NP-1:0]                   en, wren, inr, acc, rd, wr, valid;
    logic [NP-1:0][NBYTES-1:0]       be, be_eff, fwd_be, core_we;
    logic [NP-1:0][AWIDTH-1:0]       addr, core_addr;
    logic [NP-1:0][DWIDTH-1:0]       wdata, core_wdata, core_q, merged, out;
    logic                            same_addr, ww;

    assign en    = {bus.en_b, bus.en_a};
    assign wren  = {bus.wren_b, bus.wren_a};
    assign be    = {bus.be_b, bus.be_a};
    assign addr  = {bus.address_b, bus.address_a};
    assign wdata = {bus.data_b, bus.data_a};

    // Clear FSM
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
            cnt         <= '0;
            init_done_q <= 1'b0;
            collision_q <= 1'b0;
            oor_err_q   <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            init_done_q <= (state == RUN);
            collision_q <= ww;
            oor_err_q   <= |(acc & ~inr);
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            CLEAR: begin
                cnt_nx = cnt + 1'b1;
                if (cnt == LAST_W) state_nx = RUN;
            end
            RUN:     state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    assign run = (state == RUN);

    // Collision resolution: A owns every byte it enables on a shared write.
    assign same_addr = (addr[0] == addr[1]) & inr[0] & inr[1];
    assign ww        = wr[0] & wr[1] & same_addr;
    assign be_eff[0] = wr[0] ? be[0] : '0;
    assign be_eff[1] = wr[1] ? (be[1] & ~(ww ? be[0] : '0)) : '0;

    // Port A is stolen by the clear engine until RUN.
    assign core_we[0]    = run ? be_eff[0] : '1;
    assign core_addr[0]  = run ? (inr[0] ? addr[0] : '0) : cnt;
    assign core_wdata[0] = run ? wdata[0] : '0;
    assign core_we[1]    = be_eff[1];
    assign core_addr[1]  = inr[1] ? addr[1] : '0;
    assign core_wdata[1] = wdata[1];

    dpram_be_core #(
        .AWIDTH    (AWIDTH),
        .NUM_WORDS (NUM_WORDS),
        .DWIDTH    (DWIDTH)
    ) u_core (
        .clk     (clk),
        .we_a    (core_we[0]),
        .rd_a    (rd[0]),
        .addr_a  (core_addr[0]),
        .wdata_a (core_wdata[0]),
        .q_a     (core_q[0]),
        .we_b    (core_we[1]),
        .rd_b    (rd[1]),
        .addr_b  (core_addr[1]),
        .wdata_b (core_wdata[1]),
        .q_b     (core_q[1])
    );

    for (genvar p = 0; p < NP; p++) begin : g_port
        localparam int O = 1 - p;

        logic [RD_LAT:1]   vld_pipe;
        logic              oor_rd;
        logic [NBYTES-1:0] fwd_be_q;
        logic [DWIDTH-1:0] fwd_data_q;
        logic [DWIDTH-1:0] rdata_q;

        assign inr[p]    = ({1'b0, addr[p]} < DEPTH_W);
        assign acc[p]    = run & en[p];
        assign rd[p]     = acc[p] & ~wren[p];
        assign wr[p]     = acc[p] & wren[p] & inr[p];
        assign fwd_be[p] = (READ_MODE == READ_MODE_NEW && rd[p] && same_addr) ? be_eff[O] : '0;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                vld_pipe   <= '0;
                oor_rd     <= 1'b0;
                fwd_be_q   <= '0;
                fwd_data_q <= '0;
                rdata_q    <= '0;
            end else begin
                vld_pipe[1] <= rd[p];
                for (int s = 2; s <= RD_LAT; s++) vld_pipe[s] <= vld_pipe[s-1];
                if (rd[p]) begin
                    oor_rd     <= ~inr[p];
                    fwd_be_q   <= fwd_be[p];
                    fwd_data_q <= wdata[O];
                end
                if (vld_pipe[1]) rdata_q <= merged[p];
            end
        end

        // Stage-1 word: array data with forwarded bytes overlaid, zero when out of range.
        for (genvar i = 0; i < NBYTES; i++) begin : g_byte
            assign merged[p][8*i +: 8] = oor_rd      ? 8'h00 :
                                         fwd_be_q[i] ? fwd_data_q[8*i +: 8] :
                                                       core_q[p][8*i +: 8];
        end

        if (RD_LAT == 1) begin : g_lat1
            assign out[p] = vld_pipe[1] ? merged[p] : rdata_q;
        end else begin : g_lat2
            assign out[p] = rdata_q;
        end

        assign valid[p] = vld_pipe[RD_LAT];
    end

    assign bus.init_done = init_done_q;
    assign bus.collision = collision_q;
    assign bus.oor_err   = oor_err_q;
    assign bus.out_a     = out[0];
    assign bus.valid_a   = valid[0];
    assign bus.out_b     = out[1];
    assign bus.valid_b   = valid[1];

endmodule

// File: tb/tb_dpram_be_init.sv
// Scoreboard bench: two configurations (12 words/RD_LAT=2/new-data and
// 16 words/RD_LAT=1/old-data) driven by the same directed vectors.
module tb_dpram_be_init;
    localparam int AW = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic          en_a = 1'b0, wren_a = 1'b0, en_b = 1'b0, wren_b = 1'b0;
    logic [3:0]    be_a = '0, be_b = '0, addr_a = '0, addr_b = '0;
    logic [31:0]   data_a = '0, data_b = '0;

    dpram_be_init_if #(.AWIDTH(AW), .DWIDTH(DW)) if0 ();
    dpram_be_init_if #(.AWIDTH(AW), .DWIDTH(DW)) if1 ();

    assign if0.en_a = en_a;  assign if0.wren_a = wren_a;  assign if0.be_a = be_a;
    assign if0.address_a = addr_a;  assign if0.data_a = data_a;
    assign if0.en_b = en_b;  assign if0.wren_b = wren_b;  assign if0.be_b = be_b;
    assign if0.address_b = addr_b;  assign if0.data_b = data_b;
    assign if1.en_a = en_a;  assign if1.wren_a = wren_a;  assign if1.be_a = be_a;
    assign if1.address_a = addr_a;  assign if1.data_a = data_a;
    assign if1.en_b = en_b;  assign if1.wren_b = wren_b;  assign if1.be_b = be_b;
    assign if1.address_b = addr_b;  assign if1.data_b = data_b;

    dpram_be_init #(.AWIDTH(AW), .NUM_WORDS(12), .DWIDTH(DW), .RD_LAT(2),
                    .READ_MODE(1), .CLEAR_ON_RESET(1))
        dut0 (.clk(clk), .resetn(resetn), .bus(if0));
    dpram_be_init #(.AWIDTH(AW), .NUM_WORDS(16), .DWIDTH(DW), .RD_LAT(1),
                    .READ_MODE(0), .CLEAR_ON_RESET(1))
        dut1 (.clk(clk), .resetn(resetn), .bus(if1));

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    // index: 0 = dut0 A, 1 = dut0 B, 2 = dut1 A, 3 = dut1 B
    exp_t        q[4][$];
    int          lat[4] = '{2, 2, 1, 1};
    logic        vld[4];
    logic [31:0] dat[4];
    int          cyc = 0;
    int          checks = 0, failures = 0;
    int          coll_cnt[2] = '{0, 0};
    int          oor_cnt[2] = '{0, 0};
    int          r0, r1;

    assign vld[0] = if0.valid_a;  assign dat[0] = if0.out_a;
    assign vld[1] = if0.valid_b;  assign dat[1] = if0.out_b;
    assign vld[2] = if1.valid_a;  assign dat[2] = if1.out_a;
    assign vld[3] = if1.valid_b;  assign dat[3] = if1.out_b;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever a valid strobe appears.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            if (q[i].size() > 0 && q[i][0].due < cyc) begin
                checks++;
                failures++;
                $display("FAIL missing_valid[%0d] actual=none expected=%h due=%0d", i, q[i][0].data, q[i][0].due);
                void'(q[i].pop_front());
            end
            if (vld[i] === 1'b1) begin
                if (q[i].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid[%0d] actual=%h expected=no strobe", i, dat[i]);
                end else begin
                    e = q[i].pop_front();
                    check($sformatf("latency[%0d]", i), cyc, e.due);
                    check($sformatf("rdata[%0d]", i), dat[i], e.data);
                end
            end
        end
        coll_cnt[0] += int'(if0.collision);
        coll_cnt[1] += int'(if1.collision);
        oor_cnt[0]  += int'(if0.oor_err);
        oor_cnt[1]  += int'(if1.oor_err);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        en_a = 1'b0;
        en_b = 1'b0;
    endtask

    task automatic push(int i, logic [31:0] d);
        q[i].push_back('{data: d, due: cyc + lat[i]});
    endtask

    task automatic rd(int p, logic [3:0] a, logic [31:0] e0, logic [31:0] e1);
        if (p == 0) begin en_a = 1'b1; wren_a = 1'b0; addr_a = a; end
        else        begin en_b = 1'b1; wren_b = 1'b0; addr_b = a; end
        push(p, e0);
        push(2 + p, e1);
    endtask

    task automatic wr(int p, logic [3:0] a, logic [31:0] d, logic [3:0] be);
        if (p == 0) begin en_a = 1'b1; wren_a = 1'b1; addr_a = a; data_a = d; be_a = be; end
        else        begin en_b = 1'b1; wren_b = 1'b1; addr_b = a; data_b = d; be_b = be; end
    endtask

    task automatic wait_init(input bit clear_reads, output int c0, output int c1);
        c0 = 0;
        c1 = 0;
        for (int j = 1; j <= 40; j++) begin
            if (clear_reads && j <= 5) begin
                en_a = 1'b1; wren_a = 1'b0; addr_a = 4'(j);
                en_b = 1'b1; wren_b = 1'b0; addr_b = 4'(j + 6);
            end
            tick();
            if (c0 == 0 && if0.init_done === 1'b1) c0 = j;
            if (c1 == 0 && if1.init_done === 1'b1) c1 = j;
            if (c0 != 0 && c1 != 0) break;
        end
    endtask

    task automatic clr_counts();
        coll_cnt = '{0, 0};
        oor_cnt  = '{0, 0};
    endtask

    function automatic logic [31:0] mem_word(int a);
        case (a)
            3:       return 32'h2222_1111;
            5:       return 32'hAA22_CC44;
            7:       return 32'hFFFF_ABCD;
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_flags0", {27'd0, if0.init_done, if0.valid_a, if0.valid_b, if0.collision, if0.oor_err}, 32'd0);
        check("rst_flags1", {27'd0, if1.init_done, if1.valid_a, if1.valid_b, if1.collision, if1.oor_err}, 32'd0);
        check("rst_out0", if0.out_a | if0.out_b, 32'd0);
        check("rst_out1", if1.out_a | if1.out_b, 32'd0);

        // Clear: reads during CLEAR must not produce any valid.
        resetn = 1'b1;
        wait_init(1'b1, r0, r1);
        check("init_lat_12w", r0, 13);
        check("init_lat_16w", r1, 17);

        // Whole array reads back zero; 12..15 are out of range on dut0.
        clr_counts();
        for (int a = 0; a < 16; a++) begin
            rd(0, 4'(a), 32'h0, 32'h0);
            rd(1, 4'(15 - a), 32'h0, 32'h0);
            tick();
        end
        repeat (3) tick();
        check("oor_cnt_clear_scan0", oor_cnt[0], 8);
        check("oor_cnt_clear_scan1", oor_cnt[1], 0);

        // Byte enables, and a be=0 write that must be a no-op.
        wr(0, 4'd5, 32'hAABB_CCDD, 4'hF);  tick();
        wr(0, 4'd5, 32'h1122_3344, 4'b0101);  tick();
        wr(1, 4'd5, 32'hFFFF_FFFF, 4'h0);  tick();
        rd(1, 4'd5, 32'hAA22_CC44, 32'hAA22_CC44);  tick();

        // Write/write collision at addr 3.
        clr_counts();
        wr(0, 4'd3, 32'h1111_1111, 4'b0011);
        wr(1, 4'd3, 32'h2222_2222, 4'hF);
        tick();
        rd(0, 4'd3, 32'h2222_1111, 32'h2222_1111);  tick();
        rd(0, 4'd5, 32'hAA22_CC44, 32'hAA22_CC44);
        rd(1, 4'd5, 32'hAA22_CC44, 32'hAA22_CC44);
        tick();
        repeat (3) tick();
        check("collision_once0", coll_cnt[0], 1);
        check("collision_once1", coll_cnt[1], 1);

        // Cross-port read/write on addr 7, both directions.
        rd(0, 4'd7, 32'hFFFF_0000, 32'h0000_0000);
        wr(1, 4'd7, 32'hFFFF_0000, 4'b1100);
        tick();
        rd(1, 4'd7, 32'hFFFF_ABCD, 32'hFFFF_0000);
        wr(0, 4'd7, 32'h0000_ABCD, 4'b0011);
        tick();
        rd(0, 4'd7, 32'hFFFF_ABCD, 32'hFFFF_ABCD);  tick();

        // Out of range on dut0 (12 words), in range on dut1 (16 words).
        clr_counts();
        wr(0, 4'd13, 32'h0000_DEAD, 4'hF);  tick();
        rd(0, 4'd13, 32'h0, 32'h0000_DEAD);  tick();
        wr(0, 4'd14, 32'h0000_0001, 4'hF);
        wr(1, 4'd14, 32'h0000_0002, 4'hF);
        tick();
        rd(1, 4'd14, 32'h0, 32'h0000_0001);  tick();
        repeat (3) tick();
        check("oor_cnt0", oor_cnt[0], 4);
        check("oor_cnt1", oor_cnt[1], 0);
        check("oor_no_collision0", coll_cnt[0], 0);
        check("inrange_collision1", coll_cnt[1], 1);
        for (int a = 0; a < 12; a++) begin
            rd(1, 4'(a), mem_word(a), mem_word(a));
            tick();
        end
        repeat (3) tick();

        // Reset in the middle of back-to-back reads on both ports.
        for (int c = 0; c < 5; c++) begin
            rd(0, 4'd5, 32'hAA22_CC44, 32'hAA22_CC44);
            rd(1, 4'd3, 32'h2222_1111, 32'h2222_1111);
            tick();
        end
        resetn = 1'b0;
        for (int i = 0; i < 4; i++) q[i].delete();
        #1;
        check("rst_valid_drop0", {30'd0, if0.valid_a, if0.valid_b}, 32'd0);
        check("rst_valid_drop1", {30'd0, if1.valid_a, if1.valid_b}, 32'd0);
        check("rst_out_mid0", if0.out_a | if0.out_b, 32'd0);
        check("rst_out_mid1", if1.out_a | if1.out_b, 32'd0);
        check("rst_init_drop", {30'd0, if0.init_done, if1.init_done}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        wait_init(1'b0, r0, r1);
        check("reinit_lat_12w", r0, 13);
        check("reinit_lat_16w", r1, 17);
        for (int a = 0; a < 16; a++) begin
            rd(0, 4'(a), 32'h0, 32'h0);
            rd(1, 4'(a), 32'h0, 32'h0);
            tick();
        end
        repeat (4) tick();
        for (int i = 0; i < 4; i++) check($sformatf("drained[%0d]", i), q[i].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
